// File: rtl/demux1to7_seq.sv
// Registered 1-to-7 demux with valid/ready handshake, steered by sel or by a round-robin pointer.
// Latency 1 cycle; in_ready mirrors the target channel's out_ready, illegal selects always drain.
module demux1to7_seq #(
  parameter int CNT_W   = 8,
  parameter int RR_LAST = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic             mode,
  input  logic             ptr_clr,
  input  logic [6:0]       out_ready,
  output logic [6:0]       z,
  output logic [6:0]       strobe,
  output logic             err,
  output logic             frame_done,
  output logic [2:0]       rr_ptr,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [2:0] tgt;
  logic [7:0] rdy_ext;
  logic       illegal;
  logic       xfer;
  logic       legal;
  logic       wrap;
  logic [6:0] onehot;
  logic [6:0] z_nxt;
  logic [2:0] ptr_nxt;

  always_comb begin
    tgt      = mode ? rr_ptr : sel;
    illegal  = !mode && (sel == 3'd7);
    // Index 7 is only reachable through an illegal select, which must never stall.
    rdy_ext  = {1'b1, out_ready};
    in_ready = rdy_ext[tgt];
    xfer     = in_valid && in_ready;
    legal    = xfer && !illegal;
    wrap     = legal && mode && (rr_ptr == 3'(RR_LAST));
    onehot   = 7'd1 << tgt;

    z_nxt = z;
    if (legal) begin
      z_nxt = din ? (z | onehot) : (z & ~onehot);
    end

    // ptr_clr wins over an advance; the transfer itself still used the old pointer.
    ptr_nxt = rr_ptr;
    if (ptr_clr || wrap) begin
      ptr_nxt = 3'd0;
    end else if (legal && mode) begin
      ptr_nxt = rr_ptr + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z          <= 7'd0;
      strobe     <= 7'd0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      rr_ptr     <= 3'd0;
      drop_cnt   <= '0;
    end else begin
      z          <= z_nxt;
      strobe     <= legal ? onehot : 7'd0;
      err        <= xfer && illegal;
      frame_done <= wrap;
      rr_ptr     <= ptr_nxt;
      if (xfer && illegal && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux1to7_seq.sv
// Bench for demux1to7_seq: vector table plus hand-written corner sequences, scoreboard-checked.
module tb_demux1to7_seq;
  logic       clk = 1'b0;
  logic       rst_n, din, in_valid, mode, ptr_clr;
  logic [2:0] sel;
  logic [6:0] out_ready;

  logic       in_ready, err, frame_done;
  logic [6:0] z, strobe;
  logic [2:0] rr_ptr;
  logic [7:0] drop_cnt;

  logic       in_ready2, err2, frame_done2;
  logic [6:0] z2, strobe2;
  logic [2:0] rr_ptr2;
  logic [7:0] drop_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux1to7_seq #(.CNT_W(8), .RR_LAST(6)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .ptr_clr(ptr_clr), .out_ready(out_ready),
    .z(z), .strobe(strobe), .err(err), .frame_done(frame_done),
    .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
  );

  demux1to7_seq #(.CNT_W(8), .RR_LAST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready2),
    .sel(sel), .mode(mode), .ptr_clr(ptr_clr), .out_ready(out_ready),
    .z(z2), .strobe(strobe2), .err(err2), .frame_done(frame_done2),
    .rr_ptr(rr_ptr2), .drop_cnt(drop_cnt2)
  );

  typedef struct {
    logic [6:0] z;
    logic [6:0] strobe;
    logic       err;
    logic       fd;
    logic [2:0] ptr;
    logic [7:0] drop;
    logic       chk2;
    logic [6:0] strobe2;
    logic       fd2;
  } exp_t;

  typedef struct {
    logic       v, m, d;
    logic [2:0] s;
    logic       rdy;
    logic [6:0] z, st;
    logic       fd;
    logic [2:0] ptr;
    logic [6:0] st2;
    logic       fd2;
  } vec_t;

  exp_t q[$];
  vec_t vt[12];

  function automatic vec_t mk_v(logic v, logic m, logic d, logic [2:0] s, logic rdy,
                                logic [6:0] zz, logic [6:0] st, logic fd, logic [2:0] p,
                                logic [6:0] st2, logic fd2);
    vec_t r;
    r.v = v; r.m = m; r.d = d; r.s = s; r.rdy = rdy;
    r.z = zz; r.st = st; r.fd = fd; r.ptr = p; r.st2 = st2; r.fd2 = fd2;
    return r;
  endfunction

  function automatic exp_t mk_e(logic [6:0] zz, logic [6:0] st, logic e, logic fd,
                                logic [2:0] p, logic [7:0] dr);
    exp_t r;
    r.z = zz; r.strobe = st; r.err = e; r.fd = fd; r.ptr = p; r.drop = dr;
    r.chk2 = 1'b0; r.strobe2 = 7'd0; r.fd2 = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic v, input logic m, input logic c,
                     input logic d, input logic [2:0] s, input logic [6:0] o);
    rst_n = r; in_valid = v; mode = m; ptr_clr = c; din = d; sel = s; out_ready = o;
  endtask

  // Called just after the falling edge with inputs already driven.
  task automatic step(input string tag, input exp_t e, input logic chk_rdy, input logic exp_rdy);
    exp_t x;
    #1;
    if (chk_rdy) chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'(1), 32'(0));
    end else begin
      x = q.pop_front();
      chk({tag, " z"},          32'(z),          32'(x.z));
      chk({tag, " strobe"},     32'(strobe),     32'(x.strobe));
      chk({tag, " err"},        32'(err),        32'(x.err));
      chk({tag, " frame_done"}, 32'(frame_done), 32'(x.fd));
      chk({tag, " rr_ptr"},     32'(rr_ptr),     32'(x.ptr));
      chk({tag, " drop_cnt"},   32'(drop_cnt),   32'(x.drop));
      if (x.chk2) begin
        chk({tag, " strobe_rr2"},     32'(strobe2),     32'(x.strobe2));
        chk({tag, " frame_done_rr2"}, 32'(frame_done2), 32'(x.fd2));
      end
    end
  endtask

  initial begin
    exp_t e;
    logic [7:0] dr;

    //               v  m  d  sel  rdy z           strobe      fd ptr  strobe(RR_LAST=2) fd2
    vt[0]  = mk_v(1, 0, 1, 3'd3, 1, 7'b0001000, 7'b0001000, 0, 3'd0, 7'b0001000, 0);
    vt[1]  = mk_v(1, 0, 1, 3'd5, 1, 7'b0101000, 7'b0100000, 0, 3'd0, 7'b0100000, 0);
    vt[2]  = mk_v(1, 0, 0, 3'd3, 1, 7'b0100000, 7'b0001000, 0, 3'd0, 7'b0001000, 0);
    vt[3]  = mk_v(0, 0, 0, 3'd0, 1, 7'b0100000, 7'b0000000, 0, 3'd0, 7'b0000000, 0);
    vt[4]  = mk_v(1, 1, 1, 3'd7, 1, 7'b0100001, 7'b0000001, 0, 3'd1, 7'b0000001, 0);
    vt[5]  = mk_v(1, 1, 1, 3'd7, 1, 7'b0100011, 7'b0000010, 0, 3'd2, 7'b0000010, 0);
    vt[6]  = mk_v(1, 1, 1, 3'd7, 1, 7'b0100111, 7'b0000100, 0, 3'd3, 7'b0000100, 1);
    vt[7]  = mk_v(1, 1, 1, 3'd7, 1, 7'b0101111, 7'b0001000, 0, 3'd4, 7'b0000001, 0);
    vt[8]  = mk_v(1, 1, 1, 3'd7, 1, 7'b0111111, 7'b0010000, 0, 3'd5, 7'b0000010, 0);
    vt[9]  = mk_v(1, 1, 1, 3'd7, 1, 7'b0111111, 7'b0100000, 0, 3'd6, 7'b0000100, 1);
    vt[10] = mk_v(1, 1, 1, 3'd7, 1, 7'b1111111, 7'b1000000, 1, 3'd0, 7'b0000001, 0);
    vt[11] = mk_v(0, 1, 0, 3'd0, 1, 7'b1111111, 7'b0000000, 0, 3'd0, 7'b0000000, 0);

    // Reset with garbage on every input.
    drv(0, 1, 0, 0, 1, 3'd5, 7'h7F);
    step("reset0", mk_e(7'd0, 7'd0, 0, 0, 3'd0, 8'd0), 0, 0);
    drv(0, 1, 1, 1, 1, 3'd7, 7'h55);
    step("reset1", mk_e(7'd0, 7'd0, 0, 0, 3'd0, 8'd0), 0, 0);

    for (int i = 0; i < 12; i++) begin
      drv(1, vt[i].v, vt[i].m, 0, vt[i].d, vt[i].s, 7'h7F);
      e = mk_e(vt[i].z, vt[i].st, 0, vt[i].fd, vt[i].ptr, 8'd0);
      e.chk2 = 1'b1; e.strobe2 = vt[i].st2; e.fd2 = vt[i].fd2;
      step($sformatf("vec%0d", i), e, 1, vt[i].rdy);
    end

    // Illegal select drains even with every consumer stalled; counter saturates.
    for (int i = 0; i < 300; i++) begin
      drv(1, 1, 0, 0, 1, 3'd7, 7'h00);
      dr = (i >= 254) ? 8'd255 : 8'(i + 1);
      step($sformatf("illegal%0d", i), mk_e(7'b1111111, 7'd0, 1, 0, 3'd0, dr), 1, 1);
    end
    drv(1, 0, 0, 0, 1, 3'd7, 7'h00);
    step("illegal_idle", mk_e(7'b1111111, 7'd0, 0, 0, 3'd0, 8'd255), 1, 1);

    // Walk pointer to 2, then stall channel 2.
    drv(1, 1, 1, 0, 0, 3'd0, 7'h7F);
    step("bp_pre0", mk_e(7'b1111110, 7'b0000001, 0, 0, 3'd1, 8'd255), 1, 1);
    step("bp_pre1", mk_e(7'b1111100, 7'b0000010, 0, 0, 3'd2, 8'd255), 1, 1);
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 1, 0, 0, 3'd0, 7'h7B);
      step($sformatf("bp_stall%0d", i), mk_e(7'b1111100, 7'd0, 0, 0, 3'd2, 8'd255), 1, 0);
    end
    drv(1, 1, 1, 0, 0, 3'd0, 7'h7F);
    step("bp_go", mk_e(7'b1111000, 7'b0000100, 0, 0, 3'd3, 8'd255), 1, 1);
    step("bp_c3", mk_e(7'b1110000, 7'b0001000, 0, 0, 3'd4, 8'd255), 1, 1);
    step("bp_c4", mk_e(7'b1100000, 7'b0010000, 0, 0, 3'd5, 8'd255), 1, 1);
    step("bp_c5", mk_e(7'b1000000, 7'b0100000, 0, 0, 3'd6, 8'd255), 1, 1);

    // Wrap transfer and ptr_clr together.
    drv(1, 1, 1, 1, 0, 3'd0, 7'h7F);
    step("wrap_clr", mk_e(7'b0000000, 7'b1000000, 0, 1, 3'd0, 8'd255), 1, 1);

    // Mode switching: pointer holds across a directed transfer.
    drv(1, 1, 1, 0, 1, 3'd0, 7'h7F);
    step("ms_rr0", mk_e(7'b0000001, 7'b0000001, 0, 0, 3'd1, 8'd255), 1, 1);
    drv(1, 1, 0, 0, 1, 3'd4, 7'h7F);
    step("ms_dir4", mk_e(7'b0010001, 7'b0010000, 0, 0, 3'd1, 8'd255), 1, 1);
    drv(1, 1, 1, 0, 1, 3'd4, 7'h7F);
    step("ms_rr1", mk_e(7'b0010011, 7'b0000010, 0, 0, 3'd2, 8'd255), 1, 1);
    drv(1, 0, 1, 1, 0, 3'd0, 7'h7F);
    step("clr_idle", mk_e(7'b0010011, 7'd0, 0, 0, 3'd0, 8'd255), 1, 1);

    // Reset in a cycle carrying a valid transfer.
    drv(0, 1, 1, 0, 1, 3'd0, 7'h7F);
    step("rst_mid", mk_e(7'd0, 7'd0, 0, 0, 3'd0, 8'd0), 1, 1);
    drv(1, 0, 1, 0, 0, 3'd0, 7'h7F);
    step("rst_after", mk_e(7'd0, 7'd0, 0, 0, 3'd0, 8'd0), 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to7_seq.md
Name: demux1to7_seq

Overview:
- Registered 1-to-7 demultiplexer with a valid/ready handshake. It steers a single-bit input stream to one of seven output channels.
- Two steering modes: directed (by sel) and auto round-robin (internal pointer 0..6).
- Sits on the distribution side of the 7:1 selection path. It delivers bits back out to the seven per-channel consumers and holds each channel's last delivered value.

Parameters:
- CNT_W, 8, width of the saturating dropped-transfer counter
- RR_LAST, 6, highest channel index used by the round-robin pointer (legal 0..6)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- din  input  1  data bit to distribute
- in_valid  input  1  din is valid this cycle
- in_ready  output  1  block accepts din this cycle (combinational)
- sel  input  3  target channel in directed mode; 0..6 legal, 7 illegal
- mode  input  1  0 = directed by sel, 1 = auto round-robin
- ptr_clr  input  1  synchronous clear of the round-robin pointer to 0
- out_ready  input  7  per-channel consumer ready
- z  output  7  per-channel held data, registered
- strobe  output  7  one-cycle pulse, channel k updated this cycle
- err  output  1  one-cycle pulse, illegal-select transfer dropped
- frame_done  output  1  one-cycle pulse, round-robin wrapped RR_LAST->0
- rr_ptr  output  3  current round-robin pointer
- drop_cnt  output  CNT_W  saturating count of dropped transfers

Behaviour:
- Reset (rst_n=0 at clk edge): z=0, strobe=0, err=0, frame_done=0, rr_ptr=0, drop_cnt=0. Reset dominates all other inputs. A transfer presented in the reset cycle is discarded and has no later effect.
- Target channel (combinational): tgt = sel if mode=0; tgt = rr_ptr if mode=1.
- in_ready:
  - Equals out_ready[tgt] when tgt in 0..6.
  - Equals 1 when mode=0 and sel=7. Illegal selects are always drained, never stall.
- Transfer = in_valid & in_ready at a rising clk edge (rst_n=1).
- Legal transfer, latency 1 cycle:
  - z[tgt] <= din and strobe[tgt] <= 1.
  - All other z bits hold. All other strobe bits <= 0.
- Illegal transfer (mode=0, sel=7):
  - No z change; strobe <= 0; err <= 1.
  - drop_cnt increments, saturating at all-ones with no wrap.
- No transfer: strobe, err and frame_done <= 0. z holds.
- At most one strobe bit is high in any cycle.
- Round-robin pointer:
  - Advances only on a legal transfer with mode=1.
  - rr_ptr == RR_LAST -> rr_ptr <= 0 and frame_done <= 1 in the same cycle the strobe is issued.
  - Otherwise rr_ptr <= rr_ptr+1.
- ptr_clr=1:
  - rr_ptr <= 0, overriding any advance in the same cycle.
  - A transfer in that cycle still goes to the pre-clear rr_ptr, still strobes, and still raises frame_done if it was the wrap transfer.
- Mode switching:
  - Takes effect the same cycle; tgt follows the mode input combinationally.
  - rr_ptr holds its value while mode=0 and resumes from there when mode returns to 1.
- Backpressure:
  - in_valid with out_ready[tgt]=0 -> in_ready=0, no state change.
  - The producer must hold din/sel stable until transfer (producer requirement; the block does not check it).
- sel is ignored when mode=1. rr_ptr is never 7.

Test Plan:
- Reset: drive garbage with rst_n=0 for 2 cycles, then release -> z=0000000, strobe=0, err=0, rr_ptr=0, drop_cnt=0.
- Directed: mode=0, out_ready=7'h7F; send (sel=3, din=1), then (sel=5, din=1), then (sel=3, din=0).
  - Required: strobe=0001000 with z[3]=1, then strobe=0100000 with z=0101000, then z=0100000.
  - Each result appears one cycle after its transfer.
- Illegal select: mode=0, sel=7, in_valid=1 for 300 cycles.
  - Required: in_ready=1 throughout, err high each cycle after the first, z unchanged, drop_cnt saturates at 255.
- Round-robin: mode=1, 7 consecutive transfers of din=1.
  - Required: strobe walks 0000001..1000000, frame_done high only with the 7th strobe, rr_ptr=0 afterwards.
  - With RR_LAST=2 instead: wrap after 3 transfers.
- Backpressure: mode=1, rr_ptr=2, out_ready[2]=0 for 4 cycles, then 1.
  - Required: in_ready=0 for 4 cycles, no strobe. Then one transfer, strobe[2], rr_ptr=3.
- Simultaneous events: rr_ptr=6, transfer plus ptr_clr in the same cycle -> strobe[6], frame_done=1, rr_ptr=0.
- Reset mid-stream: rst_n=0 in a cycle with a valid transfer -> next cycle all outputs at reset values, no strobe.
